// File: rtl/approx_mul_pkg.sv
// Shared constants for the approximate-multiplier controller: state encoding and defaults.
package approx_mul_pkg;

    localparam int unsigned N_DEF       = 16;
    localparam int unsigned M_DEF       = 4;
    localparam int unsigned MAX_CYC_DEF = 40;
    localparam int unsigned STATE_W     = 3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_LO  = 3'd1;
    localparam logic [2:0] S_INIT     = 3'd2;
    localparam logic [2:0] S_SHIFT_AB = 3'd3;
    localparam logic [2:0] S_LOAD_Y   = 3'd4;
    localparam logic [2:0] S_SHIFT_Y  = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    // States during which the host sees the run as in progress
    function automatic logic is_busy_state(input logic [2:0] s);
        return (s == S_INIT) || (s == S_SHIFT_AB) || (s == S_LOAD_Y) || (s == S_SHIFT_Y);
    endfunction

    // States whose duration depends on the datapath and is therefore watched
    function automatic logic is_timed_state(input logic [2:0] s);
        return (s == S_SHIFT_AB) || (s == S_SHIFT_Y);
    endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// Phase watchdog: counts cycles in a watched phase and flags the MAX_CYC-th one.
module ctrl_watchdog #(
    parameter int unsigned MAX_CYC = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry is raised during the last permitted cycle so the FSM can leave on that edge
    assign expired = count_en && (cnt_q == CNT_W'(MAX_CYC - 1));

    // Next count: clear on phase change, otherwise advance while watched
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Cycle counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/approx_mul_controller.sv
// Sequencing FSM for the 16-bit approximate-multiplier datapath with start/done handshake.
module approx_mul_controller
    import approx_mul_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned M       = M_DEF,
    parameter int unsigned MAX_CYC = MAX_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic check_ovA,
    input  logic check_ovB,
    input  logic Co0,
    input  logic Co,
    output logic clr,
    output logic ldA,
    output logic enA,
    output logic enB,
    output logic ld,
    output logic enC,
    output logic busy,
    output logic done,
    output logic err
);

    // Longest legitimate watched phase: SHIFT_Y with both counts saturated
    localparam int unsigned LONGEST_PHASE = 2 * ((1 << M) - 1) + 1;

    // Configuration guards: a shift count must fit below the operand width,
    // and the watchdog must outlast the longest legitimate phase
    if ((1 << M) - 1 >= N) begin : g_cfg_shift_counter_too_wide
    end
    if (MAX_CYC <= LONGEST_PHASE) begin : g_cfg_watchdog_too_short
    end

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               err_q;
    logic               err_d;
    logic               clr_q;
    logic               ldA_q;
    logic               ld_q;
    logic               busy_q;
    logic               done_q;
    logic               wd_expired;

    ctrl_watchdog #(
        .MAX_CYC (MAX_CYC)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_d != state_q),
        .count_en (is_timed_state(state_q)),
        .expired  (wd_expired)
    );

    // Next-state, datapath-reactive enables and sticky error
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        enA     = 1'b0;
        enB     = 1'b0;
        enC     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!start) state_d = S_INIT;
            end
            S_INIT: begin
                state_d = S_SHIFT_AB;
            end
            S_SHIFT_AB: begin
                if (Co0) begin
                    state_d = S_LOAD_Y;
                end else if (wd_expired) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    enA = ~check_ovA;
                    enB = ~check_ovB;
                end
            end
            S_LOAD_Y: begin
                state_d = S_SHIFT_Y;
            end
            S_SHIFT_Y: begin
                if (Co) begin
                    state_d = S_DONE;
                end else if (wd_expired) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    enC = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_d == S_INIT) err_d = 1'b0;
    end

    // State and error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Registered Moore outputs decoded from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_q  <= 1'b0;
            ldA_q  <= 1'b0;
            ld_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            clr_q  <= (state_d == S_INIT);
            ldA_q  <= (state_d == S_INIT);
            ld_q   <= (state_d == S_LOAD_Y);
            busy_q <= is_busy_state(state_d);
            done_q <= (state_d == S_DONE);
        end
    end

    assign clr  = clr_q;
    assign ldA  = ldA_q;
    assign ld   = ld_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_approx_mul_controller.sv
// Self-checking bench: behavioural datapath plus leading-zero reference for expected run shape.
module tb_approx_mul_controller;

    localparam int MAX_CYC = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic check_ovA, check_ovB, Co0, Co;
    logic clr, ldA, enA, enB, ld, enC, busy, done, err;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural datapath
    logic [15:0] ain = '0, bin = '0;
    logic [15:0] a_r = '0, b_r = '0;
    logic [3:0]  cnt_a = '0, cnt_b = '0;
    logic [4:0]  dcnt = '0;
    bit          force_co0 = 1'b0;

    always #5 clk = ~clk;

    approx_mul_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .check_ovA(check_ovA), .check_ovB(check_ovB), .Co0(Co0), .Co(Co),
        .clr(clr), .ldA(ldA), .enA(enA), .enB(enB), .ld(ld), .enC(enC),
        .busy(busy), .done(done), .err(err)
    );

    assign check_ovA = a_r[15] || (cnt_a == 4'd15);
    assign check_ovB = b_r[15] || (cnt_b == 4'd15);
    assign Co0       = force_co0 ? 1'b0 : (check_ovA && check_ovB);
    assign Co        = (dcnt == 5'd0);

    always @(posedge clk) begin
        if (clr) begin
            cnt_a <= '0; cnt_b <= '0; dcnt <= '0;
        end
        if (ldA) begin
            a_r <= ain; b_r <= bin;
        end
        if (enA) begin
            a_r <= a_r << 1; cnt_a <= cnt_a + 4'd1;
        end
        if (enB) begin
            b_r <= b_r << 1; cnt_b <= cnt_b + 4'd1;
        end
        if (ld) dcnt <= {1'b0, cnt_a} + {1'b0, cnt_b};
        if (enC) dcnt <= dcnt - 5'd1;
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Exclusion rules checked every cycle out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            assert (!(ldA && (enA || enB)) && !(ld && enC)) else begin
                miscompares++;
                $error("FAIL excl: observed ldA=%0b enA=%0b enB=%0b ld=%0b enC=%0b expected no overlap",
                       ldA, enA, enB, ld, enC);
            end
        end
    end

    // Leading zeros, saturating at the shift-counter limit for a zero operand
    function automatic int lz16(input logic [15:0] v);
        int n = 0;
        if (v == 16'h0) return 15;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) break;
            n++;
        end
        return n;
    endfunction

    // One start pulse, then observe the whole run and compare its shape with the reference
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int hold, input bit abort_exp, input bit busy_pulse);
        int ka, kb, s, t_lda, t_ld, t_done, t_err, n_ena, n_enb, n_enc, n_done, err_init;
        bit finished;
        ka = lz16(a); kb = lz16(b); s = ka + kb;
        t_lda = -1; t_ld = -1; t_done = -1; t_err = -1;
        n_ena = 0; n_enb = 0; n_enc = 0; n_done = 0; err_init = -1; finished = 0;
        ain = a; bin = b;
        @(negedge clk); start = 1'b1;
        repeat (hold) @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (t > 0) @(negedge clk);
            if (busy_pulse && t == 3) start = 1'b1;
            if (busy_pulse && t == 6) start = 1'b0;
            if (ldA && t_lda < 0) begin t_lda = t; err_init = int'(err); end
            if (ld && t_ld < 0) t_ld = t;
            if (done && t_done < 0) t_done = t;
            if (err && t_err < 0 && t_lda >= 0) t_err = t;
            if (enA) n_ena++;
            if (enB) n_enb++;
            if (enC) n_enc++;
            if (done) n_done++;
            if (t_lda >= 0 && t > t_lda && !busy && !done) begin finished = 1; break; end
        end
        chk({tag, " finished"}, int'(finished), 1);
        chk({tag, " err@init"}, err_init, 0);
        chk({tag, " enA"}, n_ena, ka);
        chk({tag, " enB"}, n_enb, kb);
        if (!abort_exp) begin
            chk({tag, " shab len"}, t_ld - t_lda - 1, (ka > kb ? ka : kb) + 1);
            chk({tag, " enC"}, n_enc, s);
            chk({tag, " shy len"}, t_done - t_ld - 1, s + 1);
            chk({tag, " done"}, n_done, 1);
            chk({tag, " err"}, int'(err), 0);
        end else begin
            chk({tag, " err time"}, t_err - t_lda - 1, MAX_CYC);
            chk({tag, " no ld"}, t_ld, -1);
            chk({tag, " no done"}, n_done, 0);
            chk({tag, " err"}, int'(err), 1);
        end
    endtask

    // No activity for a while after a run
    task automatic idle_check(input string tag, input int cycles);
        int n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy || ldA || done) n++;
        end
        chk({tag, " idle"}, n, 0);
    endtask

    initial begin
        int wd;
        logic [15:0] ra, rb;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset outs", int'({clr, ldA, enA, enB, ld, enC, busy, done, err}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle outs", int'({clr, ldA, enA, enB, ld, enC, busy, done, err}), 0);

        run_op("t1", 16'h00F0, 16'h8000, 1, 0, 0);
        run_op("t2", 16'h8000, 16'h8000, 1, 0, 0);
        run_op("t3", 16'h0000, 16'h0003, 2, 0, 0);

        force_co0 = 1'b1;
        run_op("t4 abort", 16'h00F0, 16'h8000, 1, 1, 0);
        force_co0 = 1'b0;
        idle_check("t4", 5);
        run_op("t4 rerun", 16'h0F0F, 16'h0101, 1, 0, 0);

        // Asynchronous reset during SHIFT_Y
        ain = 16'h0010; bin = 16'h0010;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wd = 0;
        while (!ld && wd < 100) begin @(negedge clk); wd++; end
        chk("t5 reach ld", int'(ld), 1);
        repeat (3) @(negedge clk);
        chk("t5 busy pre", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1 chk("t5 async outs", int'({clr, ldA, enA, enB, ld, enC, busy, done, err}), 0);
        @(negedge clk); rst_n = 1'b1;
        run_op("t5 fresh", 16'h0F00, 16'h0F00, 1, 0, 0);

        run_op("t6 hold", 16'h0123, 16'h0040, 20, 0, 0);
        idle_check("t6 hold", 10);
        run_op("t6 busy", 16'h0020, 16'h0008, 1, 0, 1);
        idle_check("t6 busy", 10);

        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom) >> $urandom_range(0, 15);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            run_op($sformatf("rnd%0d", i), ra, rb, $urandom_range(1, 4), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
